credit_rr_mux: RTL and testbench
================================

Name: credit_rr_mux

Overview:
- Parametrised N-input, credit-gated, round-robin arbitrated output mux for the credit-based pi switch.
- Successor to the fixed 2/3/4-input combinational selectors: the block picks the next granted input itself and registers the output word.
- It also tracks downstream buffer credits, so no word is sent without space.
- Sits at each switch output port, between the input-port FIFOs and the outgoing link.

Parameters:
- N, 4, number of input channels (2..16).
- W, 32, data word width in bits.
- CREDITS, 4, downstream buffer depth; initial and maximum credit count (1..255).
- CW, $clog2(CREDITS+1), credit counter width (derived; do not override).

Ports:
- clk  input  1  switch clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_data  input  N*W  channel i occupies bits [i*W +: W].
- in_valid  input  N  channel i has a word at its FIFO head.
- in_ack  output  N  one-hot pop strobe to the granted FIFO; combinational, same cycle as grant.
- out_data  output  W  registered outgoing word.
- out_valid  output  1  registered; high for exactly one cycle per word sent.
- credit_ret  input  1  one-cycle pulse; downstream freed one slot.
- credit_cnt  output  CW  current credit count.
- credit_err  output  1  sticky; a credit was returned while the count was already CREDITS.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (rst_n).
- Reset values:
  - out_data=0, out_valid=0.
  - credit_cnt=CREDITS, credit_err=0.
  - RR pointer ptr=0.
  - in_ack=0 while rst_n=0.
- Reset mid-operation discards any in-flight grant: no ack that cycle, and out_valid=0 next cycle.
- Grant condition: any in_valid bit is set and credit_cnt>0.
- Grant selection: the first valid channel scanning ptr, ptr+1, … N-1, 0, … ptr-1.
- No grant: in_ack=0, out_valid<=0, out_data holds its value.
- On a grant to channel g:
  - in_ack[g]=1 in the same cycle.
  - out_data<=in_data[g], out_valid<=1 on the next edge (latency 1).
  - ptr<=(g+1) mod N.
- The pointer advances only on a grant.
- Throughput: one word per cycle while credits last. Ack is never gated by anything else.
- Credit update per cycle:
  - send only: cnt-1.
  - credit_ret only: cnt+1.
  - both: unchanged.
  - neither: unchanged.
- Boundary at credit_cnt=0: no grant. A credit_ret in that cycle takes effect next cycle, so the block sends on the cycle after the return.
- Boundary at credit_cnt=CREDITS:
  - credit_ret without a send is ignored (count saturates) and credit_err<=1.
  - credit_ret with a send in the same cycle leaves the count at CREDITS; no error.
- credit_err clears only on reset.
- N=1: the pointer is constant 0 and the block degenerates to a credit-gated register stage.
- Arithmetic: the counter is unsigned CW bits. The pointer is $clog2(N) bits (min 1), with an explicit wrap compare at N-1; do not rely on power-of-two overflow.
- Fairness: with all N inputs continuously valid and credits available, each channel is granted exactly once in every N consecutive grants.

Decomposition:
- Shared switch header/package:
  - channel-index width function (clog2, min 1).
  - default W and CREDITS constants, reused by the other switch-port blocks.
- Sub-module rr_arbiter #(N):
  - inputs: req[N], ptr, enable.
  - outputs: one-hot gnt[N], gnt_idx, any_gnt.
  - purely combinational.
- credit_rr_mux holds the pointer register, credit counter, output register and the W-wide N-way select, built as an AND-OR of gnt with in_data.

Test Plan:
1. Reset with rst_n=0 for 2 cycles while all in_valid=1 -> in_ack=0, out_valid=0, credit_cnt=4, credit_err=0.
2. N=4, all valid, credit_ret pulsed every cycle after the first -> grant order 0,1,2,3,0; out_data equals the matching channel word one cycle after each ack; credit_cnt stays at 3.
3. Only channel 2 valid, no credit_ret -> 4 consecutive grants to channel 2; credit_cnt goes 3,2,1,0; a 5th request is not acked.
4. At credit_cnt=0 with channel 1 valid, pulse credit_ret once -> in_ack[1]=1 on the following cycle; credit_cnt returns to 0 after the send.
5. At credit_cnt=4 with no valid input, pulse credit_ret -> credit_cnt stays 4 and credit_err=1 from the next cycle. Then, with a valid input, pulse credit_ret concurrent with the send -> count stays 4 and no new error.
6. Assert rst_n=0 in the cycle channel 3 would be granted (ptr=3) -> no ack, out_valid=0 next cycle, ptr=0; the first grant after reset goes to the lowest valid channel.

Source files
------------

// File: rtl/credit_rr_mux_pkg.sv
// Shared switch-port definitions: channel index width helper and default datapath sizing.
// Imported by every switch-port block so that W and CREDITS defaults stay consistent.
package credit_rr_mux_pkg;

    localparam int DEF_W       = 32;
    localparam int DEF_CREDITS = 4;

    // A single-channel port still needs a one-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin request picker: first set req bit scanning from ptr upward with wrap; zero latency.
// No backpressure of its own; enable=0 forces an empty grant.
module rr_arbiter
    import credit_rr_mux_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]              req,
    input  logic [idx_width(N)-1:0]   ptr,
    input  logic                      enable,
    output logic [N-1:0]              gnt,
    output logic [idx_width(N)-1:0]   gnt_idx,
    output logic                      any_gnt
);

    localparam int PW = idx_width(N);

    logic [PW-1:0] idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any_gnt = 1'b0;
        idx     = ptr;
        for (int k = 0; k < N; k++) begin
            if (enable && !any_gnt && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
                any_gnt  = 1'b1;
            end
            // Explicit wrap so non-power-of-two N never indexes past N-1.
            idx = (idx == PW'(N - 1)) ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/credit_rr_mux.sv
// Credit-gated round-robin N:1 mux; in_ack same cycle as grant, registered word one cycle later.
// Sends only while downstream credits remain; ack is the sole pop strobe to the input FIFOs.
module credit_rr_mux
    import credit_rr_mux_pkg::*;
#(
    parameter int N       = 4,
    parameter int W       = DEF_W,
    parameter int CREDITS = DEF_CREDITS,
    parameter int CW      = $clog2(CREDITS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N*W-1:0]   in_data,
    input  logic [N-1:0]     in_valid,
    output logic [N-1:0]     in_ack,
    output logic [W-1:0]     out_data,
    output logic             out_valid,
    input  logic             credit_ret,
    output logic [CW-1:0]    credit_cnt,
    output logic             credit_err
);

    localparam int PW = idx_width(N);

    logic [PW-1:0] ptr;
    logic [N-1:0]  gnt;
    logic [PW-1:0] gnt_idx;
    logic          any_gnt;
    logic          enable;
    logic [W-1:0]  sel_data;

    // Reset suppresses the grant so an in-flight pop is never lost.
    assign enable = rst_n && (credit_cnt != '0);

    rr_arbiter #(.N(N)) u_arb (
        .req     (in_valid),
        .ptr     (ptr),
        .enable  (enable),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any_gnt (any_gnt)
    );

    assign in_ack = gnt;

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N; i++) begin
            sel_data = sel_data | (in_data[i*W +: W] & {W{gnt[i]}});
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= any_gnt;
            if (any_gnt) begin
                out_data <= sel_data;
                ptr      <= (gnt_idx == PW'(N - 1)) ? '0 : gnt_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            credit_cnt <= CW'(CREDITS);
            credit_err <= 1'b0;
        end else if (any_gnt && !credit_ret) begin
            credit_cnt <= credit_cnt - 1'b1;
        end else if (!any_gnt && credit_ret) begin
            // A return with the buffer already empty is a protocol error; the count saturates.
            if (credit_cnt == CW'(CREDITS)) begin
                credit_err <= 1'b1;
            end else begin
                credit_cnt <= credit_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_credit_rr_mux.sv
// Directed vector table for the corner sequences, then random traffic against a reference model.
module tb_credit_rr_mux;

    localparam int N       = 4;
    localparam int W       = 32;
    localparam int CREDITS = 4;
    localparam int CW      = $clog2(CREDITS + 1);

    logic             clk;
    logic             rst_n;
    logic [N*W-1:0]   in_data;
    logic [N-1:0]     in_valid;
    logic [N-1:0]     in_ack;
    logic [W-1:0]     out_data;
    logic             out_valid;
    logic             credit_ret;
    logic [CW-1:0]    credit_cnt;
    logic             credit_err;

    int checks = 0;
    int errors = 0;

    credit_rr_mux #(.N(N), .W(W), .CREDITS(CREDITS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ack     (in_ack),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .credit_ret (credit_ret),
        .credit_cnt (credit_cnt),
        .credit_err (credit_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // src: channel whose word must appear on out_data after the edge, -1 = skip, -2 = zero.
    typedef struct {
        bit         rst;
        logic [3:0] valid;
        bit         ret;
        logic [3:0] exp_ack;
        int         exp_cnt;
        bit         exp_err;
        bit         exp_ov;
        int         src;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit r, input logic [3:0] v, input bit c, input logic [3:0] a,
                       input int cnt, input bit e, input bit ov, input int s);
        vec_t t;
        t.rst = r; t.valid = v; t.ret = c; t.exp_ack = a;
        t.exp_cnt = cnt; t.exp_err = e; t.exp_ov = ov; t.src = s;
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] word(input int ch, input int n);
        return 32'h1000_0000 * (ch + 1) + n;
    endfunction

    // Reference model state
    int         m_ptr, m_cnt;
    bit         m_err, m_ov;
    logic [W-1:0] m_od;

    function automatic int pick(input logic [N-1:0] v, input int p, input int cnt);
        if (cnt == 0) return -1;
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    initial begin
        logic [N-1:0] exp_ack;
        logic [W-1:0] words[N];
        logic [W-1:0] exp_od;
        int g;

        rst_n = 1'b0; in_valid = '0; credit_ret = 1'b0; in_data = '0;

        // Reset, all valid: nothing acked
        add(0, 4'hF, 0, 4'h0, 4, 0, 0, -2);
        add(0, 4'hF, 0, 4'h0, 4, 0, 0, -2);
        // All valid, returns every cycle after the first: order 0,1,2,3,0
        add(1, 4'hF, 0, 4'h1, 3, 0, 1, 0);
        add(1, 4'hF, 1, 4'h2, 3, 0, 1, 1);
        add(1, 4'hF, 1, 4'h4, 3, 0, 1, 2);
        add(1, 4'hF, 1, 4'h8, 3, 0, 1, 3);
        add(1, 4'hF, 1, 4'h1, 3, 0, 1, 0);
        // Refill to 4, then drain with only channel 2
        add(1, 4'h0, 1, 4'h0, 4, 0, 0, -1);
        add(1, 4'h4, 0, 4'h4, 3, 0, 1, 2);
        add(1, 4'h4, 0, 4'h4, 2, 0, 1, 2);
        add(1, 4'h4, 0, 4'h4, 1, 0, 1, 2);
        add(1, 4'h4, 0, 4'h4, 0, 0, 1, 2);
        add(1, 4'h4, 0, 4'h0, 0, 0, 0, -1);
        // At zero credits: a return enables a send on the following cycle
        add(1, 4'h2, 1, 4'h0, 1, 0, 0, -1);
        add(1, 4'h2, 0, 4'h2, 0, 0, 1, 1);
        add(1, 4'h2, 0, 4'h0, 0, 0, 0, -1);
        // Refill, then overflow return sets the sticky error
        add(1, 4'h0, 1, 4'h0, 1, 0, 0, -1);
        add(1, 4'h0, 1, 4'h0, 2, 0, 0, -1);
        add(1, 4'h0, 1, 4'h0, 3, 0, 0, -1);
        add(1, 4'h0, 1, 4'h0, 4, 0, 0, -1);
        add(1, 4'h0, 1, 4'h0, 4, 1, 0, -1);
        add(1, 4'h0, 0, 4'h0, 4, 1, 0, -1);
        // Reset clears the error; return concurrent with a send at full count is legal
        add(0, 4'hF, 1, 4'h0, 4, 0, 0, -2);
        add(1, 4'h1, 1, 4'h1, 4, 0, 1, 0);
        // Move ptr to 3, then reset while channel 3 would win
        add(1, 4'h4, 0, 4'h4, 3, 0, 1, 2);
        add(0, 4'hF, 0, 4'h0, 4, 0, 0, -2);
        add(1, 4'hA, 0, 4'h2, 3, 0, 1, 1);

        foreach (vecs[k]) begin
            for (int i = 0; i < N; i++) in_data[i*W +: W] = word(i, k);
            rst_n = vecs[k].rst; in_valid = vecs[k].valid; credit_ret = vecs[k].ret;
            #1;
            chk($sformatf("vec%0d in_ack", k), 64'(in_ack), 64'(vecs[k].exp_ack));
            @(posedge clk); #1;
            chk($sformatf("vec%0d credit_cnt", k), 64'(credit_cnt), 64'(vecs[k].exp_cnt));
            chk($sformatf("vec%0d credit_err", k), 64'(credit_err), 64'(vecs[k].exp_err));
            chk($sformatf("vec%0d out_valid", k), 64'(out_valid), 64'(vecs[k].exp_ov));
            if (vecs[k].src >= 0)
                chk($sformatf("vec%0d out_data", k), 64'(out_data), 64'(word(vecs[k].src, k)));
            else if (vecs[k].src == -2)
                chk($sformatf("vec%0d out_data reset", k), 64'(out_data), 64'd0);
        end

        // Random traffic; the model starts from a reset cycle.
        m_ptr = 0; m_cnt = CREDITS; m_err = 0; m_ov = 0; m_od = '0;
        rst_n = 1'b0; in_valid = '0; credit_ret = 1'b0;
        @(posedge clk); #1;
        for (int c = 0; c < 3000; c++) begin
            rst_n      = ($urandom_range(0, 199) != 0);
            in_valid   = N'($urandom);
            if ($urandom_range(0, 3) == 0) in_valid = '1;
            credit_ret = ($urandom_range(0, 99) < 45);
            for (int i = 0; i < N; i++) begin
                words[i] = $urandom;
                in_data[i*W +: W] = words[i];
            end
            #1;
            g = rst_n ? pick(in_valid, m_ptr, m_cnt) : -1;
            exp_ack = '0;
            if (g >= 0) exp_ack[g] = 1'b1;
            chk($sformatf("rnd%0d in_ack", c), 64'(in_ack), 64'(exp_ack));

            if (!rst_n) begin
                m_ptr = 0; m_cnt = CREDITS; m_err = 0; m_ov = 0; m_od = '0;
            end else begin
                m_ov = (g >= 0);
                if (g >= 0) begin
                    m_od  = words[g];
                    m_ptr = (g + 1) % N;
                end
                if (g >= 0 && !credit_ret) m_cnt = m_cnt - 1;
                else if (g < 0 && credit_ret) begin
                    if (m_cnt == CREDITS) m_err = 1;
                    else m_cnt = m_cnt + 1;
                end
            end
            exp_od = m_od;

            @(posedge clk); #1;
            chk($sformatf("rnd%0d out_valid", c), 64'(out_valid), 64'(m_ov));
            chk($sformatf("rnd%0d out_data", c), 64'(out_data), 64'(exp_od));
            chk($sformatf("rnd%0d credit_cnt", c), 64'(credit_cnt), 64'(m_cnt));
            chk($sformatf("rnd%0d credit_err", c), 64'(credit_err), 64'(m_err));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
